// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Sequences fetches from a combinational instruction ROM, buffers the fetched
//   words in a small prefetch FIFO and hands them to the decoder over a
//   valid/ready handshake. Supports branch redirects (flush + PC reload) and
//   halt requests.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            pulse: IDLE/HALT -> RUN
//   halt_req         RUN -> HALT, fetching stops, queued words stay poppable
//   redirect_valid   flush FIFO and load PC from redirect_addr (any state)
//   redirect_addr    branch target
//   rom_addr         current PC, drives the ROM
//   rom_data         ROM word for rom_addr, same cycle
//   instr_valid      FIFO head valid
//   instr_ready      decoder accepts the head when valid & ready
//   instr_data       head instruction
//   instr_pc         address the head instruction was fetched from
//   busy             state == RUN
//   halted           state == HALT
//   fetch_count      (FETCH_COUNT_EN only) saturating count of accepted words
//
// Configuration macro: FETCH_COUNT_EN adds the fetch_count port and counter.
module instruction_fetch_unit #(
    parameter int AW    = 5,
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          halt_req,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr_data,
    output logic [AW-1:0] instr_pc,
    output logic          busy,
    output logic          halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]   fetch_count
`endif
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [AW-1:0] pc;
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [AW-1:0] mem_pc   [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];

    logic empty, full, pop, push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop   = !empty && instr_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO may still accept.
    assign push  = (state == RUN) && !redirect_valid && !halt_req && (!full || pop);

    assign rom_addr    = pc;
    assign instr_valid = !empty;
    assign instr_data  = mem_data[rd_ptr[PW-1:0]];
    assign instr_pc    = mem_pc[rd_ptr[PW-1:0]];
    assign busy        = (state == RUN);
    assign halted      = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = RUN;
            RUN:     if (halt_req) state_next = HALT;
            HALT:    if (start)    state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Flush: any pop at this edge is still accepted by the decoder,
            // the FIFO simply restarts empty.
            pc     <= redirect_addr;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr[PW-1:0]]   <= pc;
                mem_data[wr_ptr[PW-1:0]] <= rom_data;
                wr_ptr                   <= wr_ptr + 1'b1;
                pc                       <= pc + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (pop && (fetch_count != '1)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          busy;
    logic          halted;
`ifdef FETCH_COUNT_EN
    logic [15:0]   fetch_count;
`endif

    logic [DW-1:0] rom [32];
    assign rom_data = rom[rom_addr];

    instruction_fetch_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .rom_addr(rom_addr), .rom_data(rom_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
        .busy(busy), .halted(halted)
`ifdef FETCH_COUNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=idle 1=running 2=halted, queue of fetched words.
    int            m_mode;
    int            m_pc;
    int            m_q_pc[$];
    int            m_q_dat[$];
    int            m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_q_pc.delete();
        m_q_dat.delete();
        m_cnt  = 0;
    endtask

    task automatic model_step();
        bit was_running;
        was_running = (m_mode == 1);
        if (m_q_pc.size() > 0 && instr_ready) begin
            void'(m_q_pc.pop_front());
            void'(m_q_dat.pop_front());
            if (m_cnt < 65535) m_cnt++;
        end
        if (was_running && halt_req) m_mode = 2;
        else if (!was_running && start) m_mode = 1;
        if (redirect_valid) begin
            m_q_pc.delete();
            m_q_dat.delete();
            m_pc = redirect_addr;
        end else if (was_running && !halt_req && m_q_pc.size() < DEPTH) begin
            m_q_pc.push_back(m_pc);
            m_q_dat.push_back(rom[m_pc]);
            m_pc = (m_pc + 1) % 32;
        end
    endtask

    task automatic compare();
        chk("rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("halted", 32'(halted), 32'(m_mode == 2));
        chk("instr_valid", 32'(instr_valid), 32'(m_q_pc.size() > 0));
        if (m_q_pc.size() > 0) begin
            chk("instr_pc", 32'(instr_pc), 32'(m_q_pc[0]));
            chk("instr_data", 32'(instr_data), 32'(m_q_dat[0]));
        end
`ifdef FETCH_COUNT_EN
        chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
    endtask

    // Called just after a negedge: drive inputs, step model on posedge, compare on negedge.
    task automatic cyc(input bit st, input bit hl, input bit rv, input int ra, input bit rdy);
        start          = st;
        halt_req       = hl;
        redirect_valid = rv;
        redirect_addr  = AW'(ra);
        instr_ready    = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        start = 0; halt_req = 0; redirect_valid = 0; instr_ready = 0;
        #1;
        model_reset();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_data", 32'(instr_data), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_COUNT_EN
        chk("rst_count", 32'(fetch_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compare();
    endtask

    // Run with ready high until the head is at target pc, bounded.
    task automatic run_to(input int target);
        int n = 0;
        while (!(instr_valid && instr_pc == AW'(target)) && n < 80) begin
            cyc(0, 0, 0, 0, 1);
            n++;
        end
        chk("run_to_reached", 32'(n < 80), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = DW'($urandom);
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: latency and sequence
        cyc(1, 0, 0, 0, 1);
        chk("t1_valid_after_start", 32'(instr_valid), 32'd0);
        cyc(0, 0, 0, 0, 1);
        chk("t1_first_valid", 32'(instr_valid), 32'd1);
        chk("t1_first_pc", 32'(instr_pc), 32'd0);
        chk("t1_first_data", 32'(instr_data), 32'(rom[0]));
        for (int i = 1; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("t1_seq_pc", 32'(instr_pc), 32'(i));
        end

        // 2: stall fills FIFO
        do_reset();
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        chk("t2_rom_addr_held", 32'(rom_addr), 32'd2);
        chk("t2_head_pc", 32'(instr_pc), 32'd0);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("t2_release_pc", 32'(instr_pc), 32'(i));
        end

        // 3: redirect flushes queue
        run_to(9);
        cyc(0, 0, 1, 24, 1);
        chk("t3_flushed", 32'(instr_valid), 32'd0);
        cyc(0, 0, 0, 0, 1);
        chk("t3_target_pc", 32'(instr_pc), 32'd24);
        chk("t3_target_data", 32'(instr_data), 32'(rom[24]));

        // 4: wrap
        run_to(30);
        cyc(0, 0, 0, 0, 1);
        chk("t4_wrap_31", 32'(instr_pc), 32'd31);
        cyc(0, 0, 0, 0, 1);
        chk("t4_wrap_0", 32'(instr_pc), 32'd0);
        cyc(0, 0, 0, 0, 1);
        chk("t4_wrap_1", 32'(instr_pc), 32'd1);

        // 5: halt and resume
        run_to(5);
        cyc(0, 1, 0, 0, 1);
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_pc_held", 32'(rom_addr), 32'd6);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        chk("t5_no_push", 32'(instr_valid), 32'd0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t5_resume_pc", 32'(instr_pc), 32'd6);

        // 6: async reset mid-run, then accept counting
        do_reset();
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 1);
`ifdef FETCH_COUNT_EN
        chk("t6_count_10", 32'(fetch_count), 32'd10);
`endif
        do_reset();

        // Random phase
        for (int i = 0; i < 32; i++) rom[i] = DW'($urandom);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 19) == 0, int'($urandom_range(0, 31)),
                    $urandom_range(0, 9) < 7);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
